// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice.
//   alu_op_e    : ALU operation codes as presented on alu_ctrl (4 and 6 are
//                 undefined; the ALU returns op1 with zero=0 for them)
//   arb_state_e : arbiter FSM states
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    SLT = 3'd5,
    SRL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Searches req starting one past last_grant, wrapping modulo N; the first
// asserted request wins. Holds no state: the pointer register lives in the
// instantiating block.
//   req        in  N   request vector
//   last_grant in  IW  index granted most recently
//   grant      out N   one-hot winner (zero when no request)
//   grant_idx  out IW  index of the winner (zero when no request)
//   any        out 1   at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Offsets 1..N visit every requester once, ending on last_grant itself,
  // so a lone requester can be granted back to back.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(last_grant) + off) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters.
// A round-robin winner's operands are registered onto alu_*, the ALU result
// and zero flag are captured one cycle later, and the result is returned on a
// valid/ready response port tagged with the requester index. One operation is
// in flight at a time; a new grant can overlap the response handshake.
//   clk, rst_n             clock; async active-low reset (deassertion is
//                          expected to be synchronised to clk upstream)
//   req_valid/req_ready    per-requester handshake, req_ready one-hot or zero
//   req_op1/op2/ctrl       packed per-requester operands, slot i at i*W
//   alu_op1/op2/ctrl       registered operands driven to the ALU
//   alu_result/alu_zero    ALU outputs
//   rsp_valid/rsp_ready    response handshake
//   rsp_id/data/zero       requester index, captured result and zero flag
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 3,
  parameter int NUM_REQ    = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op2,
  input  logic [NUM_REQ*CTRL_WIDTH-1:0]   req_ctrl,
  output logic [DATA_WIDTH-1:0]           alu_op1,
  output logic [DATA_WIDTH-1:0]           alu_op2,
  output logic [CTRL_WIDTH-1:0]           alu_ctrl,
  input  logic [DATA_WIDTH-1:0]           alu_result,
  input  logic                            alu_zero,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_zero
);

  arb_state_e              state;
  logic [ID_W-1:0]         last_grant;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_idx;
  logic                    any_req;
  logic                    grant_en;
  logic [DATA_WIDTH-1:0]   win_op1;
  logic [DATA_WIDTH-1:0]   win_op2;
  logic [CTRL_WIDTH-1:0]   win_ctrl;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (any_req)
  );

  // A grant is possible when idle, or in RESP on the very cycle the pending
  // response is taken. Gating with rst_n keeps req_ready low while reset is
  // held, even though the FSM already sits in IDLE.
  assign grant_en  = rst_n && any_req &&
                     ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign req_ready = grant_en ? grant : '0;
  assign rsp_valid = (state == RESP);

  assign win_op1  = req_op1[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign win_op2  = req_op2[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign win_ctrl = req_ctrl[int'(grant_idx)*CTRL_WIDTH +: CTRL_WIDTH];

  // alu_* are the operand registers themselves, so they only change when a
  // new operation is issued and hold their value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_ctrl   <= CTRL_WIDTH'(ADD);
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            alu_op1    <= win_op1;
            alu_op2    <= win_op2;
            alu_ctrl   <= win_ctrl;
            last_grant <= grant_idx;
            rsp_id     <= grant_idx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data <= alu_result;
          rsp_zero <= alu_zero;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            if (grant_en) begin
              alu_op1    <= win_op1;
              alu_op2    <= win_op2;
              alu_ctrl   <= win_ctrl;
              last_grant <= grant_idx;
              rsp_id     <= grant_idx;
              state      <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
